// File: rtl/div_sequencer.sv
// div_sequencer: iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, bmag, amag_in, bmag_in, nrem, nquo;
  logic [WIDTH:0]   rem_sh, trial;
  logic             sa, sb, sd, go, ge;
  assign go      = start & ~annul;
  assign stall   = (state == BUSY) || (state == ZERO) || (state == IDLE && go);
  assign amag_in = (signed_div & a[WIDTH-1]) ? -a : a;
  assign bmag_in = (signed_div & b[WIDTH-1]) ? -b : b;
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, bmag};
  // A set top bit of rem means the shifted value already exceeds any divisor.
  assign ge      = rem[WIDTH-1] | ~trial[WIDTH];
  assign nrem    = ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign nquo    = {quo[WIDTH-2:0], ge};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      bmag   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      sd     <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: if (go) begin
          if (b == '0) state <= ZERO;
          else begin
            state <= BUSY;
            sa    <= signed_div & a[WIDTH-1];
            sb    <= signed_div & b[WIDTH-1];
            sd    <= signed_div;
            quo   <= amag_in;
            bmag  <= bmag_in;
            rem   <= '0;
            cnt   <= '0;
          end
        end
        BUSY: if (annul) state <= IDLE;
        else begin
          rem <= nrem;
          quo <= nquo;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= DONE;
            ready  <= 1'b1;
            result <= {(sd & sa) ? -nrem : nrem, (sd & (sa ^ sb)) ? -nquo : nquo};
          end
        end
        ZERO: if (annul) state <= IDLE;
        else begin
          state  <= DONE;
          ready  <= 1'b1;
          result <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed vector table plus hand-written sequences for annul, reset and held start.
module tb_div_sequencer;
  logic        clk = 0, rst = 0, start = 0, signed_div = 0, annul = 0;
  logic [31:0] a = 0, b = 0;
  logic [63:0] result;
  logic        ready, stall;
  int checks = 0, errors = 0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .a(a), .b(b),
    .annul(annul), .result(result), .ready(ready), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;
  vec_t v[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_div(input string name, input logic sd, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input int lat);
    int  n;
    bit  bad_stall;
    @(negedge clk);
    start = 1; signed_div = sd; a = x; b = y;
    #1 chk({name, " stall@start"}, 64'(stall), 64'd1);
    @(posedge clk);
    #1 start = 0; a = $urandom; b = $urandom; signed_div = 1'($urandom);
    n = 0; bad_stall = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n = i;
      if (ready) break;
      if (!stall) bad_stall = 1;
    end
    chk({name, " stall held"}, 64'(bad_stall), 64'd0);
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " result"}, result, exp);
    chk({name, " stall@done"}, 64'(stall), 64'd0);
    @(negedge clk);
    chk({name, " ready pulse"}, 64'(ready), 64'd0);
    chk({name, " result held"}, result, exp);
  endtask

  initial begin
    int rdy_cnt, first, second, stall_seen;
    v[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,        32'd14},         33};
    v[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},   33};
    v[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0,        32'h80000000},   33};
    v[3]  = '{1'b0, 32'd5,          32'd0,          64'd0,                          2};
    v[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h0,        32'hFFFFFFFF},   33};
    v[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,        32'hFFFFFFFD},   33};
    v[6]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'd3},          33};
    v[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   {32'd1,        32'd1},          33};
    v[8]  = '{1'b0, 32'd3,          32'd5,          {32'd3,        32'd0},          33};
    v[9]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          {32'd1,        32'h7FFFFFFC},   33};
    v[10] = '{1'b1, 32'hFFFFFFF9,   32'd0,          64'd0,                          2};

    repeat (2) @(negedge clk);
    chk("reset result", result, 64'd0);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    rst = 1;

    for (int i = 0; i < 11; i++) do_div($sformatf("vec%0d", i), v[i].sd, v[i].a, v[i].b, v[i].res, v[i].lat);

    // start together with annul is ignored in IDLE
    @(negedge clk);
    start = 1; annul = 1; a = 32'd9; b = 32'd3;
    #1 chk("annul start stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1 start = 0; annul = 0;
    rdy_cnt = 0; stall_seen = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      rdy_cnt += int'(ready);
      stall_seen += int'(stall);
    end
    chk("annul start ready", 64'(rdy_cnt), 64'd0);
    chk("annul start busy", 64'(stall_seen), 64'd0);

    // annul mid-operation keeps prior result and allows an immediate restart
    do_div("prior", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    @(negedge clk);
    start = 1; signed_div = 0; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 start = 0;
    repeat (10) @(negedge clk);
    annul = 1;
    #1 chk("annul busy stall", 64'(stall), 64'd1);
    @(posedge clk);
    #1 annul = 0;
    @(negedge clk);
    chk("annul stall", 64'(stall), 64'd0);
    chk("annul ready", 64'(ready), 64'd0);
    chk("annul result kept", result, {32'd2, 32'd14});
    do_div("restart", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);

    // annul during divide-by-zero
    @(negedge clk);
    start = 1; a = 32'd5; b = 32'd0;
    @(posedge clk);
    #1 start = 0; annul = 1;
    @(posedge clk);
    #1 annul = 0;
    rdy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rdy_cnt += int'(ready);
    end
    chk("annul zero ready", 64'(rdy_cnt), 64'd0);
    chk("annul zero result", result, {32'd1, 32'd333});

    // start held across DONE gives two pulses 34 cycles apart
    @(negedge clk);
    start = 1; signed_div = 0; a = 32'd100; b = 32'd7;
    rdy_cnt = 0; first = 0; second = 0;
    for (int i = 1; i <= 90 && rdy_cnt < 2; i++) begin
      @(negedge clk);
      if (ready) begin
        rdy_cnt++;
        if (rdy_cnt == 1) first = i; else second = i;
      end
    end
    start = 0;
    chk("held start pulses", 64'(rdy_cnt), 64'd2);
    chk("held start first", 64'(first), 64'd33);
    chk("held start gap", 64'(second - first), 64'd34);
    chk("held start result", result, {32'd2, 32'd14});

    // asynchronous reset mid-run discards the operation
    @(negedge clk);
    start = 1; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 start = 0;
    repeat (10) @(negedge clk);
    #2 rst = 0;
    #1 chk("midreset result", result, 64'd0);
    chk("midreset ready", 64'(ready), 64'd0);
    chk("midreset stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1;
    rdy_cnt = 0; stall_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rdy_cnt += int'(ready);
      stall_seen += int'(stall);
    end
    chk("post reset ready", 64'(rdy_cnt), 64'd0);
    chk("post reset stall", 64'(stall_seen), 64'd0);
    chk("post reset result", result, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle iterative divider controller and datapath for DIV/DIVU in the five-stage MIPS core. It sits in the EX stage beside the ALU and accepts an operand pair when the decoder flags a divide. It stalls the pipeline while iterating and delivers {remainder, quotient} for the HI/LO register write. The block sequences one radix-2 restoring-division step per cycle and handles sign correction, divide-by-zero and pipeline flush.

Parameters:
WIDTH  32  operand width; result is 2*WIDTH bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request a divide; sampled only in IDLE
signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start
a  input  WIDTH  dividend; sampled with start
b  input  WIDTH  divisor; sampled with start
annul  input  1  flush from hazard/exception logic; aborts the operation in flight
result  output  2*WIDTH  {HI = remainder, LO = quotient}
ready  output  1  one-cycle pulse; result valid this cycle
stall  output  1  hold IF/ID/EX while the divide is pending

Behaviour:
- States:
  - IDLE, BUSY, ZERO, DONE.
  - Encoding is free, but reset must land in IDLE.
- Reset (rst = 0, asynchronous):
  - state = IDLE, iteration counter = 0, internal regs = 0.
  - result = 0, ready = 0, stall = 0.
  - Reset asserted mid-operation discards all work; no ready pulse follows.
- IDLE:
  - start = 1 and annul = 0, b != 0: latch sign flags, |a|, |b| and signed_div; clear the partial remainder; counter = 0; go to BUSY.
  - start = 1 and annul = 0, b == 0: go to ZERO.
  - start = 1 and annul = 1: ignore the start and stay in IDLE.
  - Magnitude rule: |x| = two's complement of x when signed_div and x[WIDTH-1] are both set; otherwise x unchanged.
- BUSY, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem - |b|, computed WIDTH+1 bits wide.
  - If the trial is non-negative: rem = trial and quo[0] = 1; otherwise quo[0] = 0.
  - Counter increments each step. After step WIDTH (counter == WIDTH-1 at the clock edge), go to DONE.
- Sign correction on entry to DONE, signed only:
  - Quotient negated when a-sign XOR b-sign.
  - Remainder negated when a-sign is set.
  - 0x80000000 / 0xFFFFFFFF wraps naturally: quotient 0x80000000, remainder 0. No trap.
- ZERO: one cycle, then DONE with result = 0 (divide-by-zero result is architecturally unpredictable; the team fixes it to 0).
- DONE:
  - ready = 1 for exactly this cycle; result updated at entry to DONE and held afterwards until the next DONE or reset.
  - Always returns to IDLE next cycle. A start asserted in DONE is ignored; software cannot issue back-to-back divides without an IDLE cycle.
- stall, combinational:
  - High when state is BUSY or ZERO, or when state is IDLE with start = 1 and annul = 0.
  - Low in DONE and otherwise.
- Latency:
  - start accepted at edge T (in IDLE); DONE/ready during cycle T+WIDTH+1 (T+33 for WIDTH = 32).
  - Divide-by-zero: ready during cycle T+2.
- annul:
  - In BUSY or ZERO: go to IDLE at the next edge. No ready pulse; result unchanged; stall drops once back in IDLE.
  - In DONE: ready still pulses, since the result is already committed.
- Operand changes on a, b and signed_div after acceptance have no effect.

Test Plan:
- Reset then idle: rst low mid-run, release -> result = 0, ready = 0, stall = 0; no spurious ready for 40 cycles.
- DIVU 100 / 7: start at T -> stall high T..T+32; ready at T+33 with result = {0x00000002, 0x0000000E}; stall low at T+33.
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002) -> result = {0xFFFFFFFF, 0xFFFFFFFD}. Also DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- Divide-by-zero: DIVU 5 / 0 -> ready at T+2, result = 0, stall high for exactly 2 cycles.
- Annul at step 10 of DIVU 1000 / 3 -> IDLE next cycle, no ready, result retains its prior value. A new start immediately after produces the correct {1, 333} at T'+33.
- Start held high across DONE: the second start is ignored in DONE and accepted on the following IDLE cycle, giving two ready pulses 34 cycles apart.
